// File: rtl/uart_tx_stim_if.sv
// Write-side and serial-side signal bundle for the UART stimulus transmitter.
// The bench drives the master side; the transmitter owns the slave side.
interface uart_tx_stim_if #(
    parameter int FIFO_AW = 4
) ();
    logic               wr_en;
    logic [7:0]         wr_data;
    logic               full;
    logic               empty;
    logic [FIFO_AW:0]   count;
    logic               ovf;
    logic               tx_busy;
    logic               tx_end;
    logic               tx;

    modport master (
        output wr_en, wr_data,
        input  full, empty, count, ovf,
        input  tx_busy, tx_end, tx
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, count, ovf,
        output tx_busy, tx_end, tx
    );
endinterface

// File: rtl/uart_tx_stim.sv
// Byte-buffered 8N1 UART transmitter, LSB first, frames back-to-back.
// FIFO status and serial outputs are all registered.
module uart_tx_stim #(
    parameter int DIV        = 260,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_stim_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_e;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW + 1)'(FIFO_DEPTH);

    state_e             state_q, state_d;
    logic [15:0]        div_q, div_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               full_q, empty_q, ovf_q;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               end_q, end_d;
    logic               push, pop, div_wrap;

    assign push     = bus.wr_en && !full_q;
    assign div_wrap = (div_q == DIV_LAST);

    assign wptr_d  = wptr_q + FIFO_AW'(push);
    assign rptr_d  = rptr_q + FIFO_AW'(pop);
    assign count_d = count_q + (FIFO_AW + 1)'(push)
                             - (FIFO_AW + 1)'(pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH);
            empty_q <= (count_d == '0);
            ovf_q   <= ovf_q | (bus.wr_en & full_q);
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            end_q   <= end_d;
        end
    end

    // Storage needs no reset: stale entries are never read past the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= bus.wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    div_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (div_wrap) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            S_DATA: begin
                if (div_wrap) begin
                    div_d   = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            S_STOP: begin
                if (div_wrap) begin
                    div_d = '0;
                    if (!empty_q) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from next state so they register in step with it.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != S_IDLE);
        end_d  = (state_d == S_STOP) && (div_d == DIV_LAST);
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign bus.full    = full_q;
    assign bus.empty   = empty_q;
    assign bus.count   = count_q;
    assign bus.ovf     = ovf_q;
    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_end  = end_q;
endmodule

// File: tb/tb_uart_tx_stim.sv
// Directed and randomized checks of the UART stimulus transmitter
// against a frame-level line model.
module tb_uart_tx_stim;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int FRAME = 10 * DIV;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   frames;
    int   n_sent;
    bit   mon_en;
    int   mc;
    logic [7:0] mcur;
    logic [7:0] exp_q[$];

    uart_tx_stim_if #(.FIFO_AW(AW)) bus ();

    uart_tx_stim #(
        .DIV(DIV),
        .FIFO_DEPTH(DEPTH),
        .FIFO_AW(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input bit keep);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        if (keep) begin
            exp_q.push_back(d);
            n_sent++;
        end
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_end();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.tx_end === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("tx_end_seen", 32'(got), 32'd1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (exp_q.size() == 0 && bus.tx_busy === 1'b0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk("drain", 32'(done), 32'd1);
    endtask

    // Paced stream: first burst fills the FIFO, then one byte per
    // frame time or slower so the FIFO can never overflow.
    task automatic stream(input int n, input bit rnd);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? 8'($urandom) : 8'(i);
            wr(d, 1'b1);
            if (i >= DEPTH - 1) begin
                repeat ($urandom_range(FRAME, FRAME + 20)) tick();
            end
        end
    endtask

    // Line monitor: each frame is compared cycle by cycle against
    // {stop, byte, start}, each bit DIV clocks long.
    always @(negedge clk) begin
        int idx;
        logic expbit;
        if (!mon_en) begin
            mc = 0;
        end else begin
            if (mc == 0 && bus.tx === 1'b0) begin
                chk("unexp_frame", 32'(exp_q.size() != 0), 32'd1);
                mcur = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                mc = 1;
            end
            if (mc > 0) begin
                idx = (mc - 1) / DIV;
                if (idx == 0) expbit = 1'b0;
                else if (idx == 9) expbit = 1'b1;
                else expbit = mcur[idx-1];
                chk("line_bit", 32'(bus.tx), 32'(expbit));
                chk("tx_end", 32'(bus.tx_end), 32'(mc == FRAME));
                chk("busy_frame", 32'(bus.tx_busy), 32'd1);
                if (mc == FRAME) begin
                    frames++;
                    mc = 0;
                end else begin
                    mc++;
                end
            end else begin
                chk("busy_idle", 32'(bus.tx_busy), 32'd0);
                chk("end_idle", 32'(bus.tx_end), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t3 [6];
        checks      = 0;
        failures    = 0;
        frames      = 0;
        n_sent      = 0;
        mon_en      = 1'b0;
        mc          = 0;
        reset       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(bus.tx), 32'd1);
        chk("rst_busy", 32'(bus.tx_busy), 32'd0);
        chk("rst_end", 32'(bus.tx_end), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;
        tick();

        // single byte latency
        wr(8'h55, 1'b1);
        chk("t1_count_e0", 32'(bus.count), 32'd1);
        chk("t1_tx_e0", 32'(bus.tx), 32'd1);
        tick();
        chk("t1_count_e1", 32'(bus.count), 32'd0);
        chk("t1_tx_e1", 32'(bus.tx), 32'd0);
        chk("t1_busy_e1", 32'(bus.tx_busy), 32'd1);
        chk("t1_empty_e1", 32'(bus.empty), 32'd1);
        wait_idle();

        // three back-to-back frames
        wr(8'h41, 1'b1);
        wr(8'h42, 1'b1);
        wr(8'h43, 1'b1);
        chk("t2_count", 32'(bus.count), 32'd2);
        wait_end();
        tick();
        chk("t2_tx_gap1", 32'(bus.tx), 32'd0);
        chk("t2_count1", 32'(bus.count), 32'd1);
        chk("t2_empty1", 32'(bus.empty), 32'd0);
        wait_end();
        tick();
        chk("t2_tx_gap2", 32'(bus.tx), 32'd0);
        chk("t2_empty2", 32'(bus.empty), 32'd1);
        chk("t2_count2", 32'(bus.count), 32'd0);
        wait_idle();

        // push and pop on the same edge at the end of STOP
        wr(8'hC1, 1'b1);
        wr(8'hC2, 1'b1);
        chk("t5_count_pre", 32'(bus.count), 32'd1);
        wait_end();
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hC3;
        exp_q.push_back(8'hC3);
        n_sent++;
        tick();
        bus.wr_en = 1'b0;
        chk("t5_count", 32'(bus.count), 32'd1);
        chk("t5_restart", 32'(bus.tx), 32'd0);
        wait_idle();

        // pointer wrap with an incrementing stream, then random bytes
        stream(40, 1'b0);
        wait_idle();
        chk("t4_ovf", 32'(bus.ovf), 32'd0);
        stream(12, 1'b1);
        wait_idle();
        chk("rnd_ovf", 32'(bus.ovf), 32'd0);

        // overflow while the first frame holds the line
        for (int i = 0; i < 6; i++) t3[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) wr(t3[i], i < 5);
        chk("t3_full", 32'(bus.full), 32'd1);
        chk("t3_count", 32'(bus.count), 32'd4);
        chk("t3_ovf", 32'(bus.ovf), 32'd1);
        wait_idle();
        chk("t3_ovf_sticky", 32'(bus.ovf), 32'd1);
        chk("t3_empty", 32'(bus.empty), 32'd1);

        // asynchronous reset in the middle of data bit 3
        wr(8'h3C, 1'b1);
        wr(8'h99, 1'b1);
        repeat (17) tick();
        mon_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("t6_tx", 32'(bus.tx), 32'd1);
        chk("t6_busy", 32'(bus.tx_busy), 32'd0);
        chk("t6_empty", 32'(bus.empty), 32'd1);
        chk("t6_count", 32'(bus.count), 32'd0);
        chk("t6_ovf", 32'(bus.ovf), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        exp_q.delete();
        n_sent -= 2;
        mon_en = 1'b1;
        tick();
        wr(8'hA5, 1'b1);
        wait_idle();
        chk("frames", 32'(frames), 32'(n_sent));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
